// File: rtl/rst_seq.sv
// Staged reset sequencer: synchronises the PLL-qualified reset, releases downstream
// reset domains in order, and handles soft-reset, watchdog and sticky reset cause.
module rst_seq #(
  parameter int NUM_STAGES     = 4,
  parameter int STAGE_GAP      = 16,
  parameter int SOFT_RST_PULSE = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk_0_out,
  input  logic                  ext_rst_low_in,
  input  logic                  sys_rst_low_in,
  input  logic                  soft_rst_req_in,
  input  logic                  wdt_en_in,
  input  logic                  wdt_kick_in,
  input  logic [15:0]           wdt_timeout_in,
  input  logic                  rst_cause_clr_in,
  output logic [NUM_STAGES-1:0] stage_rst_low_out,
  output logic                  all_rst_done_out,
  output logic [2:0]            rst_cause_out
);

  // state   | meaning
  // HOLD    | all stages asserted, waiting for synchronised system reset release
  // RELEASE | releasing stages one per STAGE_GAP cycles, bit 0 first
  // RUN     | all stages released, watchdog may count
  // SOFT    | all stages held for SOFT_RST_PULSE cycles after soft/watchdog event
  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_SOFT    = 2'd3;

  localparam int CNT_MAX = (STAGE_GAP > SOFT_RST_PULSE) ? STAGE_GAP : SOFT_RST_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(SOFT_RST_PULSE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst_n;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0]  stage_q, stage_d;
  logic                   done_q, done_d;
  logic [2:0]             cause_q, cause_d;
  logic [15:0]            wdt_q, wdt_d;
  logic                   wdt_counting, wdt_expire;

  assign sync_rst_n   = sync_q[SYNC_STAGES-1];
  assign wdt_counting = (state_q == ST_RUN) && wdt_en_in && (wdt_timeout_in != 16'd0);
  assign wdt_expire   = wdt_counting && !wdt_kick_in && (wdt_q == wdt_timeout_in - 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    cause_d = rst_cause_clr_in ? 3'b000 : cause_q;
    wdt_d   = (wdt_counting && !wdt_kick_in) ? wdt_q + 16'd1 : 16'd0;
    // Loss of the system reset overrides any soft/watchdog event on the same edge.
    if (!sync_rst_n && state_q != ST_HOLD) begin
      state_d    = ST_HOLD;
      stage_d    = '0;
      done_d     = 1'b0;
      cnt_d      = '0;
      idx_d      = '0;
      cause_d[0] = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          stage_d = '0;
          done_d  = 1'b0;
          if (sync_rst_n) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_TC) begin
            cnt_d   = '0;
            stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
            if (idx_q == LAST_IDX) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (soft_rst_req_in || wdt_expire) begin
            state_d    = ST_SOFT;
            stage_d    = '0;
            done_d     = 1'b0;
            cnt_d      = '0;
            wdt_d      = 16'd0;
            cause_d[1] = cause_d[1] | soft_rst_req_in;
            cause_d[2] = cause_d[2] | wdt_expire;
          end
        end
        ST_SOFT: begin
          if (cnt_q == PULSE_TC) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk_0_out or negedge ext_rst_low_in) begin
    if (!ext_rst_low_in) begin
      sync_q  <= '0;
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      cause_q <= 3'b001;
      wdt_q   <= 16'd0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sys_rst_low_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      wdt_q   <= wdt_d;
    end
  end

  assign stage_rst_low_out = stage_q;
  assign all_rst_done_out  = done_q;
  assign rst_cause_out     = cause_q;

endmodule
